// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Two-master to one-slave Avalon-MM style arbiter in front of an SDRAM
//   controller. One command is in flight at a time: the arbiter grants a
//   master from IDLE, passes its command through combinationally while it
//   owns the slave, and drops back to IDLE on acceptance. Read ownership is
//   remembered in a small ID FIFO so returning read data is steered to the
//   master that issued the read.
//
// Parameters
//   ADDR_W   word address width
//   DATA_W   data width (byteenable is DATA_W/8)
//   MAX_PEND maximum outstanding reads, power of two in 2..16
//
// Configuration macro
//   ARB_FIXED_PRIO_M0_EN  defined: M0 wins every contention in IDLE.
//                         undefined (default): round-robin between M0/M1.
//
// Ports
//   clk_clk, reset_reset_n   clock, synchronous active-low reset
//   m0_* / m1_*              master ports (address/read/write/writedata/
//                            byteenable in; waitrequest/readdata/
//                            readdatavalid out)
//   s_*                      slave port towards the SDRAM controller
//   err_orphan               sticky: read data arrived with nothing pending
module sdram_port_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,

  output logic                err_orphan
);

  localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} state_t;

  state_t state, state_nxt;

  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    pend_cnt;
  logic [MAX_PEND-1:0] id_fifo;

  logic full, m0_req, m1_req, m0_elig, m1_elig, m1_wins;
  logic own_m0, own_m1, accept, push, pop, orphan, head_id;

  assign full    = (pend_cnt == CNT_W'(MAX_PEND));
  assign m0_req  = m0_read | m0_write;
  assign m1_req  = m1_read | m1_write;
  // A full ID FIFO only blocks reads; writes never need a return slot.
  assign m0_elig = m0_write | (m0_read & ~full);
  assign m1_elig = m1_write | (m1_read & ~full);

  assign own_m0  = (state == OWN_M0);
  assign own_m1  = (state == OWN_M1);
  // A master that drops its request while owning is not an acceptance.
  assign accept  = ~s_waitrequest & ((own_m0 & m0_req) | (own_m1 & m1_req));
  assign push    = ~s_waitrequest & ((own_m0 & m0_read) | (own_m1 & m1_read));
  assign pop     = s_readdatavalid & (pend_cnt != '0);
  assign orphan  = s_readdatavalid & (pend_cnt == '0);
  assign head_id = id_fifo[rd_ptr];

`ifdef ARB_FIXED_PRIO_M0_EN
  assign m1_wins = 1'b0;
`else
  // Remembers who was served last; reset value makes M0 the first winner.
  logic rr_last_m1;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n)
      rr_last_m1 <= 1'b1;
    else if (accept)
      rr_last_m1 <= own_m1;
  end

  assign m1_wins = ~rr_last_m1;
`endif

  // State register
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_elig && m1_elig)
          state_nxt = m1_wins ? OWN_M1 : OWN_M0;
        else if (m0_elig)
          state_nxt = OWN_M0;
        else if (m1_elig)
          state_nxt = OWN_M1;
      end
      OWN_M0:  if (!m0_req || !s_waitrequest) state_nxt = IDLE;
      OWN_M1:  if (!m1_req || !s_waitrequest) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: owner's command is passed straight through. Outputs are
  // also forced quiet while reset is low so nothing leaks before the first
  // clock edge of reset.
  always_comb begin
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_address      = m0_address;
    s_writedata    = m0_writedata;
    s_byteenable   = m0_byteenable;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (reset_reset_n) begin
      case (state)
        OWN_M0: begin
          s_read         = m0_read;
          s_write        = m0_write;
          m0_waitrequest = s_waitrequest;
        end
        OWN_M1: begin
          s_read         = m1_read;
          s_write        = m1_write;
          s_address      = m1_address;
          s_writedata    = m1_writedata;
          s_byteenable   = m1_byteenable;
          m1_waitrequest = s_waitrequest;
        end
        default: ;
      endcase
    end
  end

  // Read-return steering
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = reset_reset_n & pop & ~head_id;
  assign m1_readdatavalid = reset_reset_n & pop &  head_id;

  // ID FIFO storage (contents are qualified by pend_cnt, so no reset needed)
  always_ff @(posedge clk_clk) begin
    if (push)
      id_fifo[wr_ptr] <= own_m1;
  end

  // ID FIFO pointers/count and orphan flag. Pointers wrap naturally because
  // MAX_PEND is a power of two.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pend_cnt   <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        pend_cnt <= pend_cnt + CNT_W'(1);
      else if (pop && !push)
        pend_cnt <= pend_cnt - CNT_W'(1);
      if (orphan) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 32;
  localparam int MAX_PEND = 4;
  localparam int BE_W     = DATA_W / 8;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic              m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
  logic              m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic              m0_readdatavalid, m1_readdatavalid, s_readdatavalid;
  logic              err_orphan;

  int checks = 0;
  int errors = 0;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '1;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '1;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; idle_inputs(); tick(); tick(); rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs();
    m0_read = 1; m1_write = 1; s_readdatavalid = 1;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, err_orphan} !== 7'b0011000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0011000", {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, err_orphan});
    end
    tick(); idle_inputs(); rst_n = 1;
    @(negedge clk);
    checks++;
    if ({s_read, s_write, m0_waitrequest, m1_waitrequest, err_orphan} !== 5'b00110) begin
      errors++;
      $display("FAIL reset_release got %b exp 00110", {s_read, s_write, m0_waitrequest, m1_waitrequest, err_orphan});
    end
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_address = 25'h0000010; m0_read = 1; s_waitrequest = 0;
    @(negedge clk);
    checks++;
    if ({s_read, m0_waitrequest} !== 2'b01) begin
      errors++; $display("FAIL rd_cycle0 got %b exp 01", {s_read, m0_waitrequest});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({s_read, m0_waitrequest, m1_waitrequest} !== 3'b101 || s_address !== 25'h0000010) begin
      errors++;
      $display("FAIL rd_cycle1 got %b addr %h exp 101 addr 0000010", {s_read, m0_waitrequest, m1_waitrequest}, s_address);
    end
    tick(); m0_read = 0;
    tick(); tick();
    s_readdatavalid = 1; s_readdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10 || m0_readdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_return got %b data %h exp 10 data deadbeef", {m0_readdatavalid, m1_readdatavalid}, m0_readdata);
    end
    tick(); s_readdatavalid = 0;
    @(negedge clk);
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid, err_orphan} !== 3'b000) begin
      errors++; $display("FAIL rd_after got %b exp 000", {m0_readdatavalid, m1_readdatavalid, err_orphan});
    end
    tick();
  endtask

  task automatic test_round_robin();
    int n = 0;
    int g, e;
    do_reset();
    m0_write = 1; m0_address = 25'h0A0; m0_writedata = 32'h11111111;
    m1_write = 1; m1_address = 25'h0B0; m1_writedata = 32'h22222222;
    for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
      @(negedge clk);
      if (s_write && (!m0_waitrequest || !m1_waitrequest)) begin
        g = m0_waitrequest ? 1 : 0;
`ifdef ARB_FIXED_PRIO_M0_EN
        e = 0;
`else
        e = n % 2;
`endif
        checks++;
        if (g != e || s_address !== (e == 1 ? 25'h0B0 : 25'h0A0)) begin
          errors++; $display("FAIL rr_grant%0d got M%0d addr %h exp M%0d", n, g, s_address, e);
        end
        n++;
      end
      tick();
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL rr_count got %0d exp 8", n); end
    m0_write = 0; m1_write = 0;
    tick();
  endtask

  task automatic test_wait_hold();
    do_reset();
    m1_write = 1; m1_address = 25'h55; m1_writedata = 32'h1234; m1_byteenable = 4'h3;
    s_waitrequest = 1;
    tick();
    m0_write = 1; m0_address = 25'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({s_write, s_read, m1_waitrequest, m0_waitrequest} !== 4'b1011 || s_address !== 25'h55 ||
          s_writedata !== 32'h1234 || s_byteenable !== 4'h3) begin
        errors++;
        $display("FAIL hold%0d got %b addr %h data %h be %h exp 1011 55 1234 3", i,
                 {s_write, s_read, m1_waitrequest, m0_waitrequest}, s_address, s_writedata, s_byteenable);
      end
      tick();
    end
    s_waitrequest = 0;
    @(negedge clk);
    checks++;
    if ({m1_waitrequest, m0_waitrequest} !== 2'b01) begin
      errors++; $display("FAIL hold_release got %b exp 01", {m1_waitrequest, m0_waitrequest});
    end
    tick(); m1_write = 0;
    tick();
    @(negedge clk);
    checks++;
    if ({m0_waitrequest, s_address} !== {1'b0, 25'hAA}) begin
      errors++; $display("FAIL hold_next got wait %b addr %h exp 0 aa", m0_waitrequest, s_address);
    end
    tick(); m0_write = 0;
  endtask

  task automatic test_pending_limit();
    int ids[4] = '{0, 1, 0, 1};
    bit got;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      got = 0;
      if (ids[k] == 0) begin m0_read = 1; m0_address = ADDR_W'(32'h100 + k); end
      else             begin m1_read = 1; m1_address = ADDR_W'(32'h100 + k); end
      for (int c = 0; c < 6 && !got; c++) begin
        @(negedge clk);
        if (ids[k] == 0 ? !m0_waitrequest : !m1_waitrequest) got = 1;
        tick();
      end
      m0_read = 0; m1_read = 0;
      checks++;
      if (!got) begin errors++; $display("FAIL pend_issue%0d got nogrant exp grant", k); end
    end
    m0_read = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({s_read, m0_waitrequest} !== 2'b01) begin
        errors++; $display("FAIL pend_full_block%0d got %b exp 01", c, {s_read, m0_waitrequest});
      end
      tick();
    end
    m1_write = 1; got = 0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (!m1_waitrequest && s_write && !s_read) got = 1;
      tick();
    end
    m1_write = 0;
    checks++;
    if (!got) begin errors++; $display("FAIL pend_write_while_full got nogrant exp grant"); end
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b1) begin
      errors++; $display("FAIL pend_still_blocked got %b exp 1", m0_waitrequest);
    end
    tick(); m0_read = 0;
    for (int k = 0; k < 4; k++) begin
      s_readdatavalid = 1; s_readdata = 32'hC0DE0000 + k;
      @(negedge clk);
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid} !== (ids[k] == 1 ? 2'b01 : 2'b10) ||
          m0_readdata !== 32'hC0DE0000 + k || m1_readdata !== 32'hC0DE0000 + k) begin
        errors++;
        $display("FAIL pend_return%0d got %b data %h exp M%0d data %h", k,
                 {m0_readdatavalid, m1_readdatavalid}, m0_readdata, ids[k], 32'hC0DE0000 + k);
      end
      tick();
    end
    s_readdatavalid = 0;
    @(negedge clk);
    checks++;
    if (err_orphan !== 1'b0) begin errors++; $display("FAIL pend_no_orphan got %b exp 0", err_orphan); end
    tick();
  endtask

  task automatic test_orphan();
    do_reset();
    s_readdatavalid = 1; s_readdata = 32'hBAD;
    @(negedge clk);
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      errors++; $display("FAIL orphan_drop got %b exp 00", {m0_readdatavalid, m1_readdatavalid});
    end
    tick(); s_readdatavalid = 0;
    @(negedge clk);
    checks++;
    if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set got %b exp 1", err_orphan); end
    tick(); tick();
    @(negedge clk);
    checks++;
    if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %b exp 1", err_orphan); end
    rst_n = 0; tick();
    @(negedge clk);
    checks++;
    if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_clear got %b exp 0", err_orphan); end
    rst_n = 1; tick();
  endtask

  task automatic test_reset_pending();
    bit got;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      got = 0;
      if (k == 0) m0_read = 1; else m1_read = 1;
      for (int c = 0; c < 6 && !got; c++) begin
        @(negedge clk);
        if (k == 0 ? !m0_waitrequest : !m1_waitrequest) got = 1;
        tick();
      end
      m0_read = 0; m1_read = 0;
      checks++;
      if (!got) begin errors++; $display("FAIL rstpend_issue%0d got nogrant exp grant", k); end
    end
    rst_n = 0; tick(); rst_n = 1; tick();
    s_readdatavalid = 1;
    @(negedge clk);
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid, err_orphan} !== 3'b000) begin
      errors++; $display("FAIL rstpend_drop got %b exp 000", {m0_readdatavalid, m1_readdatavalid, err_orphan});
    end
    tick(); s_readdatavalid = 0;
    @(negedge clk);
    checks++;
    if (err_orphan !== 1'b1) begin errors++; $display("FAIL rstpend_orphan got %b exp 1", err_orphan); end
    tick();
  endtask

  // Reference model: who holds the slave (-1 none), who was served last,
  // and the ordered list of masters waiting on read data.
  task automatic test_random();
    int owner, last, n, r;
    int q[$];
    int cmd[2];
    bit orph, e0, e1, req, accept;
    logic [6:0] exp_ctl;
    logic exp_rd, exp_wr, exp_v0, exp_v1;
    do_reset();
    owner = -1; last = 1; orph = 0; q.delete(); cmd[0] = 0; cmd[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        r = $urandom_range(0, 9);
        if (owner == m) begin
          if (r < 2) cmd[m] = 0;   // a granted master may only hold or withdraw
        end else begin
          cmd[m] = (r < 4) ? 0 : (r < 7) ? 1 : 2;
          if (m == 0) begin
            m0_address = ADDR_W'($urandom); m0_writedata = $urandom; m0_byteenable = BE_W'($urandom);
          end else begin
            m1_address = ADDR_W'($urandom); m1_writedata = $urandom; m1_byteenable = BE_W'($urandom);
          end
        end
      end
      m0_read = (cmd[0] == 1); m0_write = (cmd[0] == 2);
      m1_read = (cmd[1] == 1); m1_write = (cmd[1] == 2);
      s_waitrequest   = ($urandom_range(0, 2) == 0);
      s_readdatavalid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      s_readdata      = $urandom;
      @(negedge clk);
      exp_rd = (owner == 0) ? m0_read  : (owner == 1) ? m1_read  : 1'b0;
      exp_wr = (owner == 0) ? m0_write : (owner == 1) ? m1_write : 1'b0;
      exp_v0 = s_readdatavalid && q.size() > 0 && q[0] == 0;
      exp_v1 = s_readdatavalid && q.size() > 0 && q[0] == 1;
      exp_ctl = {exp_rd, exp_wr, !(owner == 0 && !s_waitrequest), !(owner == 1 && !s_waitrequest),
                 exp_v0, exp_v1, orph};
      checks++;
      if ({s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, err_orphan} !== exp_ctl) begin
        errors++;
        $display("FAIL rand_ctl cyc %0d got %b exp %b", cyc,
                 {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, err_orphan}, exp_ctl);
      end
      if (owner >= 0) begin
        checks++;
        if (s_address !== (owner == 1 ? m1_address : m0_address) ||
            s_writedata !== (owner == 1 ? m1_writedata : m0_writedata) ||
            s_byteenable !== (owner == 1 ? m1_byteenable : m0_byteenable)) begin
          errors++;
          $display("FAIL rand_cmd cyc %0d got addr %h data %h be %h exp owner M%0d", cyc,
                   s_address, s_writedata, s_byteenable, owner);
        end
      end
      if (exp_v0 || exp_v1) begin
        checks++;
        if (m0_readdata !== s_readdata || m1_readdata !== s_readdata) begin
          errors++; $display("FAIL rand_rdata cyc %0d got %h/%h exp %h", cyc, m0_readdata, m1_readdata, s_readdata);
        end
      end
      // advance model by one clock
      n = q.size();
      accept = 0;
      if (owner < 0) begin
        e0 = m0_write || (m0_read && n < MAX_PEND);
        e1 = m1_write || (m1_read && n < MAX_PEND);
`ifdef ARB_FIXED_PRIO_M0_EN
        owner = e0 ? 0 : e1 ? 1 : -1;
`else
        owner = (e0 && e1) ? 1 - last : e0 ? 0 : e1 ? 1 : -1;
`endif
      end else begin
        req = (owner == 0) ? (m0_read || m0_write) : (m1_read || m1_write);
        if (!req) owner = -1;
        else if (!s_waitrequest) accept = 1;
      end
      if (s_readdatavalid) begin
        if (n > 0) void'(q.pop_front());
        else orph = 1;
      end
      if (accept) begin
        last = owner;
        if (owner == 0 ? m0_read : m1_read) q.push_back(owner);
        owner = -1;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_hold();
    test_pending_limit();
    test_orphan();
    test_reset_pending();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
